// File: rtl/shifter_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : shifter_arbiter_if
// Brief    : Bundle of the two requester handshakes and the tagged response
//            channel around the shared shifter. The master modport is the
//            requester/consumer side. The slave modport is the arbiter side.
// Revision : 1.0  initial release
// ============================================================================
interface shifter_arbiter_if #(
  parameter int DATA_W = 16
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_Rs;
  logic [3:0]        req0_Imm;
  logic [1:0]        req0_mode;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_Rs;
  logic [3:0]        req1_Imm;
  logic [1:0]        req1_mode;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_Rd;
  logic              resp_id;
  logic              resp_err;

  modport master (
    output req0_valid, req0_Rs, req0_Imm, req0_mode,
    output req1_valid, req1_Rs, req1_Imm, req1_mode,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_Rd, resp_id, resp_err
  );

  modport slave (
    input  req0_valid, req0_Rs, req0_Imm, req0_mode,
    input  req1_valid, req1_Rs, req1_Imm, req1_mode,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_Rd, resp_id, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/shifter_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : shifter_arbiter
// Brief    : Shares one 16-bit SLL/SRA/ROR shifter between two requesters.
//            The arbiter grants in IDLE, latches the operands, and shifts
//            from registers for one cycle. It then holds a tagged result
//            until the consumer takes it.
// Config   : SHARB_RR_EN defined   -> round-robin tie-break (rr_last_q)
//            SHARB_RR_EN undefined -> fixed priority, req0 wins ties
// Revision : 1.0  initial release
// ============================================================================
module shifter_arbiter #(
  parameter int DATA_W      = 16,
  parameter bit BYPASS_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  shifter_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_RESP  = 2'b10
  } state_t;

  localparam logic [4:0] c_rot_w   = 5'(DATA_W);
  localparam logic [1:0] c_mode_bad = 2'b11;

  state_t            state_q;
  logic [DATA_W-1:0] op_rs_q;
  logic [3:0]        op_imm_q;
  logic [1:0]        op_mode_q;
  logic              op_id_q;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rd_q;
  logic              resp_id_q;
  logic              resp_err_q;
`ifdef SHARB_RR_EN
  logic              rr_last_q;
`endif

  logic              grant_id;
  logic              grant_any;
  logic              idle_ok;
  logic [DATA_W-1:0] sel_rs;
  logic [3:0]        sel_imm;
  logic [1:0]        sel_mode;
  logic              sel_bypass;
  logic [DATA_W-1:0] sh_out;

  // Tie-break: either a rotating preference or a fixed preference for req0.
`ifdef SHARB_RR_EN
  assign grant_id  = bus.req1_valid & (~bus.req0_valid | ~rr_last_q);
`else
  assign grant_id  = bus.req1_valid & ~bus.req0_valid;
`endif
  assign grant_any = bus.req0_valid | bus.req1_valid;

  // While reset is held, the readies are forced low. This keeps every
  // output at zero even when a requester is already presenting valid.
  assign idle_ok        = (state_q == ST_IDLE) & rst_n;
  assign bus.req0_ready = idle_ok & bus.req0_valid & ~grant_id;
  assign bus.req1_ready = idle_ok & grant_id;

  assign sel_rs     = grant_id ? bus.req1_Rs   : bus.req0_Rs;
  assign sel_imm    = grant_id ? bus.req1_Imm  : bus.req0_Imm;
  assign sel_mode   = grant_id ? bus.req1_mode : bus.req0_mode;
  assign sel_bypass = BYPASS_ZERO && (sel_imm == 4'd0);

  // Shared combinational shifter, fed only from the latched operands.
  always_comb begin
    sh_out = op_rs_q;
    case (op_mode_q)
      2'b00:   sh_out = op_rs_q << op_imm_q;
      2'b01:   sh_out = $unsigned($signed(op_rs_q) >>> op_imm_q);
      2'b10:   sh_out = (op_rs_q >> op_imm_q) |
                        (op_rs_q << (c_rot_w - {1'b0, op_imm_q}));
      default: sh_out = op_rs_q;
    endcase
  end

  // Control FSM with registered operand latches and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_rs_q      <= '0;
      op_imm_q     <= '0;
      op_mode_q    <= '0;
      op_id_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rd_q    <= '0;
      resp_id_q    <= 1'b0;
      resp_err_q   <= 1'b0;
`ifdef SHARB_RR_EN
      rr_last_q    <= 1'b1;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_any) begin
            op_rs_q   <= sel_rs;
            op_imm_q  <= sel_imm;
            op_mode_q <= sel_mode;
            op_id_q   <= grant_id;
`ifdef SHARB_RR_EN
            rr_last_q <= grant_id;
`endif
            if (sel_bypass) begin
              // A zero shift amount leaves the operand unchanged in every mode,
              // so the result can be returned without using the shifter.
              resp_rd_q    <= sel_rs;
              resp_id_q    <= grant_id;
              resp_err_q   <= (sel_mode == c_mode_bad);
              resp_valid_q <= 1'b1;
              state_q      <= ST_RESP;
            end else begin
              state_q      <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          resp_rd_q    <= sh_out;
          resp_id_q    <= op_id_q;
          resp_err_q   <= (op_mode_q == c_mode_bad);
          resp_valid_q <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_Rd    = resp_rd_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_err   = resp_err_q;

endmodule
`default_nettype wire
